// File: rtl/memory_port_arbiter_pkg.sv
// memory_arbiter_pkg: shared widths, clear FSM encoding and client ids for the memory port arbiter.
package memory_arbiter_pkg;
  localparam int DEFAULT_ADDRESS_WIDTH = 9;
  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_DEPTH = 512;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;
endpackage

// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if: client read/write ports, clear control and memory-side bus of the arbiter.
interface memory_port_arbiter_if
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic c0_read_request, c1_read_request;
  logic [ADDRESS_WIDTH-1:0] c0_read_address, c1_read_address;
  logic c0_read_grant, c1_read_grant;
  logic [DATA_WIDTH-1:0] c0_read_data, c1_read_data;
  logic c0_read_data_valid, c1_read_data_valid;
  logic c0_write_request, c1_write_request;
  logic [ADDRESS_WIDTH-1:0] c0_write_address, c1_write_address;
  logic [DATA_WIDTH-1:0] c0_write_data, c1_write_data;
  logic c0_write_grant, c1_write_grant;
  logic clear_start;
  logic [DATA_WIDTH-1:0] clear_value;
  logic clear_busy, clear_done;
  logic mem_perform_read;
  logic [ADDRESS_WIDTH-1:0] mem_read_address;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic mem_read_data_ready;
  logic mem_perform_write;
  logic [ADDRESS_WIDTH-1:0] mem_write_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  modport slave (
    input c0_read_request, c1_read_request, c0_read_address, c1_read_address,
    output c0_read_grant, c1_read_grant, c0_read_data, c1_read_data,
    output c0_read_data_valid, c1_read_data_valid,
    input c0_write_request, c1_write_request, c0_write_address, c1_write_address,
    input c0_write_data, c1_write_data,
    output c0_write_grant, c1_write_grant,
    input clear_start, clear_value,
    output clear_busy, clear_done,
    output mem_perform_read, mem_read_address,
    input mem_read_data, mem_read_data_ready,
    output mem_perform_write, mem_write_address, mem_write_data
  );
  modport master (
    output c0_read_request, c1_read_request, c0_read_address, c1_read_address,
    input c0_read_grant, c1_read_grant, c0_read_data, c1_read_data,
    input c0_read_data_valid, c1_read_data_valid,
    output c0_write_request, c1_write_request, c0_write_address, c1_write_address,
    output c0_write_data, c1_write_data,
    input c0_write_grant, c1_write_grant,
    output clear_start, clear_value,
    input clear_busy, clear_done,
    input mem_perform_read, mem_read_address,
    output mem_read_data, mem_read_data_ready,
    input mem_perform_write, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/memory_port_arbiter_round_robin_2.sv
// round_robin_2: two-client round-robin arbiter; grants are combinational, pointer flips to the loser on each grant.
module round_robin_2
  import memory_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] request,
  input  logic       force_zero,
  output logic [1:0] grant
);
  logic pointer;
  logic [1:0] live;
  // Gating with reset_n keeps every grant low for the whole reset window.
  assign live = request & {2{reset_n & ~force_zero}};
  assign grant[0] = live[0] & (~live[1] | (pointer == CLIENT0));
  assign grant[1] = live[1] & (~live[0] | (pointer == CLIENT1));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) pointer <= CLIENT0;
    else if (|grant) pointer <= grant[0] ? CLIENT1 : CLIENT0;
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one dual-ported memory between two clients and a full-array clear sequencer.
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
)(
  input logic clock,
  input logic reset_n,
  memory_port_arbiter_if.slave bus
);
  localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);
  logic [1:0] rd_grant, wr_grant;
  logic read_owner;
  logic [0:0] state;
  logic clearing;
  logic [ADDRESS_WIDTH-1:0] clear_counter;
  logic [DATA_WIDTH-1:0] clear_latched;
  logic clear_done_q;
  assign clearing = state == CLEAR;
  round_robin_2 u_read (
    .clock(clock),
    .reset_n(reset_n),
    .request({bus.c1_read_request, bus.c0_read_request}),
    .force_zero(1'b0),
    .grant(rd_grant)
  );
  round_robin_2 u_write (
    .clock(clock),
    .reset_n(reset_n),
    .request({bus.c1_write_request, bus.c0_write_request}),
    .force_zero(clearing),
    .grant(wr_grant)
  );
  assign bus.c0_read_grant = rd_grant[0];
  assign bus.c1_read_grant = rd_grant[1];
  assign bus.mem_perform_read = |rd_grant;
  assign bus.mem_read_address = rd_grant[1] ? bus.c1_read_address : bus.c0_read_address;
  assign bus.c0_read_data = bus.mem_read_data;
  assign bus.c1_read_data = bus.mem_read_data;
  assign bus.c0_read_data_valid = bus.mem_read_data_ready & (read_owner == CLIENT0);
  assign bus.c1_read_data_valid = bus.mem_read_data_ready & (read_owner == CLIENT1);
  assign bus.c0_write_grant = wr_grant[0];
  assign bus.c1_write_grant = wr_grant[1];
  // The sweep owns the write port outright; client grants are already forced low while clearing.
  assign bus.mem_perform_write = clearing | (|wr_grant);
  assign bus.mem_write_address = clearing ? clear_counter : wr_grant[1] ? bus.c1_write_address : bus.c0_write_address;
  assign bus.mem_write_data = clearing ? clear_latched : wr_grant[1] ? bus.c1_write_data : bus.c0_write_data;
  assign bus.clear_busy = clearing;
  assign bus.clear_done = clear_done_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      read_owner <= CLIENT0;
      state <= IDLE;
      clear_counter <= '0;
      clear_latched <= '0;
      clear_done_q <= 1'b0;
    end else begin
      if (|rd_grant) read_owner <= rd_grant[1] ? CLIENT1 : CLIENT0;
      clear_done_q <= clearing && clear_counter == LAST;
      if (!clearing && bus.clear_start) begin
        state <= CLEAR;
        clear_counter <= '0;
        clear_latched <= bus.clear_value;
      end else if (clearing) begin
        clear_counter <= clear_counter + ADDRESS_WIDTH'(1);
        if (clear_counter == LAST) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed checks of read/write arbitration and the clear sweep against a 512x24 memory model.
module tb_memory_port_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int busy_cnt, done_cnt, viol;
  logic prev_busy;
  logic [23:0] mem [512];
  logic pl_en = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [23:0] pl_data = '0;

  memory_port_arbiter_if bus ();
  memory_port_arbiter dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  // Read-before-write memory with 1-cycle read latency, plus a bench preload port.
  initial bus.mem_read_data_ready = 1'b0;
  always @(posedge clock) begin
    if (bus.mem_perform_read) bus.mem_read_data <= mem[bus.mem_read_address];
    bus.mem_read_data_ready <= bus.mem_perform_read;
    if (bus.mem_perform_write) mem[bus.mem_write_address] <= bus.mem_write_data;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [8:0] a, input logic [23:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    bus.c0_read_request = 0; bus.c1_read_request = 0;
    bus.c0_read_address = '0; bus.c1_read_address = '0;
    bus.c0_write_request = 0; bus.c1_write_request = 0;
    bus.c0_write_address = '0; bus.c1_write_address = '0;
    bus.c0_write_data = '0; bus.c1_write_data = '0;
    bus.clear_start = 0; bus.clear_value = '0;
    #2;
    bus.c0_read_request = 1; bus.c1_read_request = 1;
    bus.c0_write_request = 1; bus.c1_write_request = 1;
    #1;
    check("rst_rd_grant", 32'({bus.c1_read_grant, bus.c0_read_grant}), 32'd0);
    check("rst_wr_grant", 32'({bus.c1_write_grant, bus.c0_write_grant}), 32'd0);
    check("rst_mem_ctl", 32'({bus.mem_perform_read, bus.mem_perform_write}), 32'd0);
    check("rst_clear", 32'({bus.clear_busy, bus.clear_done}), 32'd0);
    bus.c0_read_request = 0; bus.c1_read_request = 0;
    bus.c0_write_request = 0; bus.c1_write_request = 0;
    preload(9'h005, 24'hABCDEF);
    preload(9'h010, 24'h111111);
    preload(9'h020, 24'h222222);
    preload(9'h1FF, 24'h0F0F0F);
    preload(9'h000, 24'h999999);
    reset_n = 1'b1;
    tick();
    // Single c0 read
    bus.c0_read_request = 1; bus.c0_read_address = 9'h005;
    #1;
    check("t1_grant", 32'({bus.c1_read_grant, bus.c0_read_grant}), 32'd1);
    check("t1_mem_rd", 32'({bus.mem_perform_read, bus.mem_read_address}), 32'h205);
    tick();
    bus.c0_read_request = 0;
    check("t1_valid", 32'({bus.c1_read_data_valid, bus.c0_read_data_valid}), 32'd1);
    check("t1_data", 32'(bus.c0_read_data), 32'hABCDEF);
    // Both read continuously; pointer now favours c1
    bus.c0_read_request = 1; bus.c0_read_address = 9'h010;
    bus.c1_read_request = 1; bus.c1_read_address = 9'h020;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("alt_grant", 32'({bus.c1_read_grant, bus.c0_read_grant}), (i % 2 == 0) ? 32'd2 : 32'd1);
      check("alt_addr", 32'(bus.mem_read_address), (i % 2 == 0) ? 32'h020 : 32'h010);
      tick();
      check("alt_valid", 32'({bus.c1_read_data_valid, bus.c0_read_data_valid}), (i % 2 == 0) ? 32'd2 : 32'd1);
      check("alt_data", 32'(bus.c0_read_data), (i % 2 == 0) ? 32'h222222 : 32'h111111);
    end
    bus.c0_read_request = 0; bus.c1_read_request = 0;
    tick();
    // Same-cycle write and read of 0x1FF
    bus.c1_write_request = 1; bus.c1_write_address = 9'h1FF; bus.c1_write_data = 24'h123456;
    bus.c0_read_request = 1; bus.c0_read_address = 9'h1FF;
    #1;
    check("rw_wgrant", 32'({bus.c1_write_grant, bus.c0_write_grant}), 32'd2);
    check("rw_rgrant", 32'({bus.c1_read_grant, bus.c0_read_grant}), 32'd1);
    check("rw_mem_wr", 32'({bus.mem_perform_write, bus.mem_write_address}), 32'h3FF);
    tick();
    bus.c1_write_request = 0;
    check("rw_old", 32'({bus.c0_read_data_valid, bus.c0_read_data}), 32'h10F0F0F);
    tick();
    bus.c0_read_request = 0;
    check("rw_new", 32'({bus.c0_read_data_valid, bus.c0_read_data}), 32'h1123456);
    // Full clear sweep with c0 write held and a second clear_start mid-sweep
    bus.clear_value = 24'h000000; bus.clear_start = 1;
    bus.c0_write_request = 1; bus.c0_write_address = 9'h050; bus.c0_write_data = 24'h777777;
    tick();
    bus.clear_start = 0; bus.clear_value = 24'h555555;
    busy_cnt = 0; done_cnt = 0; viol = 0; prev_busy = 1'b0;
    for (int i = 0; i < 530; i++) begin
      if (bus.clear_busy) busy_cnt++;
      if (bus.clear_busy && bus.c0_write_grant) viol++;
      if (bus.clear_done) done_cnt++;
      if (prev_busy && !bus.clear_busy) begin
        check("clr_done_edge", 32'(bus.clear_done), 32'd1);
        check("clr_c0_after", 32'(bus.c0_write_grant), 32'd1);
      end
      bus.clear_start = (busy_cnt == 200 && bus.clear_busy);
      prev_busy = bus.clear_busy;
      tick();
    end
    bus.clear_start = 0;
    bus.c0_write_request = 0;
    check("clr_busy_len", 32'(busy_cnt), 32'd512);
    check("clr_grant_viol", 32'(viol), 32'd0);
    check("clr_done_cnt", 32'(done_cnt), 32'd1);
    bus.c0_read_request = 1; bus.c0_read_address = 9'h000;
    tick();
    bus.c0_read_address = 9'h1FF;
    check("clr_rd_000", 32'({bus.c0_read_data_valid, bus.c0_read_data}), 32'h1000000);
    tick();
    bus.c0_read_request = 0;
    check("clr_rd_1ff", 32'({bus.c0_read_data_valid, bus.c0_read_data}), 32'h1000000);
    // Reset during the sweep at cycle 100
    preload(9'h063, 24'hAAAAAA);
    preload(9'h064, 24'hBBBBBB);
    bus.clear_value = 24'h3C3C3C; bus.clear_start = 1;
    tick();
    bus.clear_start = 0;
    repeat (100) tick();
    check("mid_busy_pre", 32'(bus.clear_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_busy_drop", 32'(bus.clear_busy), 32'd0);
    check("mid_no_write", 32'(bus.mem_perform_write), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) reset_n = 1'b1;
      tick();
      if (bus.clear_done) done_cnt++;
    end
    check("mid_no_done", 32'(done_cnt), 32'd0);
    bus.c1_read_request = 1; bus.c1_read_address = 9'h063;
    tick();
    bus.c1_read_address = 9'h064;
    check("mid_rd_063", 32'({bus.c1_read_data_valid, bus.c1_read_data}), 32'h13C3C3C);
    tick();
    bus.c1_read_request = 0;
    check("mid_rd_064", 32'({bus.c1_read_data_valid, bus.c1_read_data}), 32'h1BBBBBB);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the 512x24 dual-ported block memory between two clients and an internal clear sequencer.
- Read port: round-robin arbitration between client 0 and client 1, with the 1-cycle read response routed back to the owning client.
- Write port: round-robin between the clients, with the clear sequencer taking absolute priority while it sweeps the whole array.
- Sits directly between the memory instance and the pixel/processing logic that previously drove it point-to-point.

Parameters:
- ADDRESS_WIDTH, 9, memory address width.
- DATA_WIDTH, 24, memory word width.
- DEPTH, 512, number of words swept by the clear sequencer; must equal 2**ADDRESS_WIDTH.

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- c0_read_request, c1_read_request  in  1  read request, held until granted.
- c0_read_address, c1_read_address  in  ADDRESS_WIDTH  read address, stable while request high.
- c0_read_grant, c1_read_grant  out  1  combinational; request accepted this cycle.
- c0_read_data, c1_read_data  out  DATA_WIDTH  mem_read_data passthrough.
- c0_read_data_valid, c1_read_data_valid  out  1  response strobe for that client.
- c0_write_request, c1_write_request  in  1  write request.
- c0_write_address, c1_write_address  in  ADDRESS_WIDTH  write address.
- c0_write_data, c1_write_data  in  DATA_WIDTH  write data.
- c0_write_grant, c1_write_grant  out  1  combinational; write performed this cycle.
- clear_start  in  1  single-cycle pulse; start the clear sweep.
- clear_value  in  DATA_WIDTH  fill word, sampled when clear_start is accepted.
- clear_busy  out  1  clear sweep in progress.
- clear_done  out  1  one-cycle pulse after the last word is written.
- mem_perform_read  out  1  to memory.
- mem_read_address  out  ADDRESS_WIDTH  to memory.
- mem_read_data  in  DATA_WIDTH  from memory.
- mem_read_data_ready  in  1  from memory; asserted 1 cycle after mem_perform_read.
- mem_perform_write  out  1  to memory.
- mem_write_address  out  ADDRESS_WIDTH  to memory.
- mem_write_data  out  DATA_WIDTH  to memory.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Both priority pointers are 0 (client 0 favoured).
  - read_owner is 0.
  - FSM is IDLE and clear_counter is 0.
  - clear_busy and clear_done are 0.
  - All grants and mem_perform_read/mem_perform_write are forced to 0 while reset_n is low; no memory write can occur during reset.
- Read arbitration (combinational):
  - Exactly one request high: that client is granted.
  - Both high: the client indicated by rd_pointer is granted.
  - On any grant, rd_pointer <= the other client.
  - mem_perform_read = any grant; mem_read_address = the granted client's address.
  - read_owner <= the granted client id.
- Read response:
  - cX_read_data_valid = mem_read_data_ready AND (read_owner == X). Total latency is 1 cycle from grant.
  - Back-to-back grants to alternating clients every cycle are supported at full throughput.
- Write arbitration: identical scheme with an independent wr_pointer, except that while FSM=CLEAR both client write grants are 0.
- Clear FSM:
  - IDLE -> CLEAR on clear_start: clear_counter <= 0, latch clear_value, clear_busy <= 1.
  - CLEAR, each cycle: mem_perform_write = 1, address = clear_counter, data = latched value, clear_counter <= clear_counter + 1.
  - CLEAR: on the cycle writing address DEPTH-1, next state is IDLE with clear_busy <= 0 and clear_done <= 1 for exactly one cycle.
  - The sweep takes exactly DEPTH cycles.
  - clear_start while in CLEAR is ignored.
  - Reads stay arbitrated normally during CLEAR.
- Same-cycle read and write to one address: the read returns the old contents (memory read-before-write); the arbiter adds no forwarding.
- Reset mid-sweep: the sweep is aborted, no clear_done pulse is produced, and the partial contents remain.
- A request held high with no grant must keep its address/data stable; clients may drop a request without being granted.

Decomposition:
- Shared package `memory_arbiter_pkg`:
  - ADDRESS_WIDTH/DATA_WIDTH/DEPTH defaults.
  - Clear FSM state encoding (IDLE=0, CLEAR=1).
  - Client id constants CLIENT0=0, CLIENT1=1.
- One sub-module `round_robin_2`: 2-input request, grant outputs, pointer register with asynchronous active-low reset. Instantiate it twice (read and write), with a force-zero input on the write instance during CLEAR.

Test Plan:
- After reset, c0_read_request=1 @0x005 alone -> c0_read_grant=1 the same cycle; mem_perform_read=1 to address 0x005; next cycle c0_read_data_valid=1 with the preloaded word 0xABCDEF; c1_read_data_valid=0.
- Both clients request reads continuously (c0 @0x010, c1 @0x020) -> grants alternate c0,c1,c0,c1…; each valid strobe reaches only its owner with the correct data.
- c1 writes 0x123456 @0x1FF while c0 reads 0x1FF in the same cycle -> c0 gets the old value; a read of 0x1FF one cycle later returns 0x123456.
- clear_start with clear_value=0x000000 while c0_write_request is held -> clear_busy high for 512 cycles; c0_write_grant=0 throughout; clear_done pulses once; c0 is granted on the next cycle; reads of 0x000 and 0x1FF return 0.
- reset_n low at clear cycle 100 -> clear_busy drops immediately; no clear_done; address 0x063 holds clear_value; address 0x064 keeps its previous data.
- A second clear_start mid-sweep -> ignored; total clear_busy duration is still exactly 512 cycles.
